alu_pipe: RTL

Parametrised, registered successor to the team's 8-bit combinational ALU. It uses the same 3-bit operation encodings, zero-extended into a 4-bit opcode, and the same flag semantics. It adds shift operations and a multi-cycle unsigned multiply. Operands enter and results leave through valid/ready handshakes, so the block sits between an issue stage and a writeback stage and tolerates backpressure from either side.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_seq_mul.sv | 67 ++++++
 rtl/alu_pipe.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag helpers for the pipelined ALU and its benches.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_NOT = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_INC = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_DEC = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SHL = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SHR = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_ASR = 4'd10;
    localparam logic [ALU_OP_W-1:0] ALU_MUL = 4'd11;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ILLEGAL_MIN = 4'd12;

    // Signed overflow from operand and result sign bits.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add unsigned multiplier: one partial-product step per clock for WIDTH clocks.
module alu_seq_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic [2*WIDTH-1:0] addend_s;
    logic [2*WIDTH-1:0] acc_next_s;

    // Partial product for the current step; product is the completed value on the last step.
    always_comb begin
        if (mplier_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {(2*WIDTH){1'b0}};
        end
        acc_next_s = acc_r + addend_s;
    end

    assign busy    = busy_r;
    assign done    = busy_r && (cnt_r == LAST_STEP);
    assign product = acc_next_s;

    // Operand load on start, then one shift-add step per clock until the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= {(2*WIDTH){1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
        end else if (start) begin
            mcand_r  <= {{WIDTH{1'b0}}, a};
            acc_r    <= {(2*WIDTH){1'b0}};
            mplier_r <= b;
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= acc_next_s;
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            busy_r   <= (cnt_r != LAST_STEP);
        end else begin
            busy_r   <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides; single-cycle ops plus a sequential multiply.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [ALU_OP_W-1:0] alu_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                carry_out,
    output logic                zero,
    output logic                overflow,
    output logic                err
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic MUL_ON = (MUL_EN == 32'sd1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_MUL_BUSY = 1'b1;

    logic [0:0]         state_r;
    logic               run_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   result_r;
    logic               carry_r;
    logic               zero_r;
    logic               ovf_r;
    logic               err_r;

    logic               in_ready_s;
    logic               accept_s;
    logic               xfer_s;
    logic               is_mul_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     sub_s;
    logic [WIDTH:0]     inc_s;
    logic [WIDTH:0]     dec_s;
    logic [WIDTH:0]     shl_s;
    logic [WIDTH:0]     shr_s;
    logic [WIDTH:0]     asr_s;
    logic [WIDTH-1:0]   res_s;
    logic               carry_s;
    logic               ovf_s;
    logic               err_s;
    logic               mul_busy_s;
    logic               mul_done_s;
    logic [2*WIDTH-1:0] mul_prod_s;
    logic               mul_hi_s;

    // run_r keeps in_ready low through reset and the first clock after release.
    assign in_ready_s = run_r && (state_r == ST_IDLE) && (!out_valid_r || out_ready);
    assign accept_s   = in_valid && in_ready_s;
    assign xfer_s     = out_valid_r && out_ready;
    assign is_mul_s   = MUL_ON && (alu_op == ALU_MUL);
    assign shamt_s    = b[SHAMT_W-1:0];
    assign mul_hi_s   = |mul_prod_s[2*WIDTH-1:WIDTH];

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign carry_out = carry_r;
    assign zero      = zero_r;
    assign overflow  = ovf_r;
    assign err       = err_r;

    generate
        if (MUL_ON) begin : g_mul
            alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (accept_s && is_mul_s),
                .a       (a),
                .b       (b),
                .busy    (mul_busy_s),
                .done    (mul_done_s),
                .product (mul_prod_s)
            );
        end else begin : g_no_mul
            assign mul_busy_s = 1'b0;
            assign mul_done_s = 1'b0;
            assign mul_prod_s = {(2*WIDTH){1'b0}};
        end
    endgenerate

    // Single-cycle datapath; shifts carry an extra bit on the exit side to catch the last bit out.
    always_comb begin
        add_s = {1'b0, a} + {1'b0, b};
        sub_s = {1'b0, a} - {1'b0, b};
        inc_s = {1'b0, a} + {1'b0, ONE};
        dec_s = {1'b0, a} - {1'b0, ONE};
        shl_s = {1'b0, a} << shamt_s;
        shr_s = {a, 1'b0} >> shamt_s;
        asr_s = $signed({a, 1'b0}) >>> shamt_s;
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        err_s   = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                res_s   = add_s[WIDTH-1:0];
                carry_s = add_s[WIDTH];
                ovf_s   = add_ovf(a[WIDTH-1], b[WIDTH-1], add_s[WIDTH-1]);
            end
            ALU_SUB: begin
                res_s   = sub_s[WIDTH-1:0];
                carry_s = sub_s[WIDTH];
                ovf_s   = sub_ovf(a[WIDTH-1], b[WIDTH-1], sub_s[WIDTH-1]);
            end
            ALU_AND: res_s = a & b;
            ALU_OR:  res_s = a | b;
            ALU_XOR: res_s = a ^ b;
            ALU_NOT: res_s = ~a;
            ALU_INC: begin
                res_s   = inc_s[WIDTH-1:0];
                carry_s = inc_s[WIDTH];
                ovf_s   = add_ovf(a[WIDTH-1], 1'b0, inc_s[WIDTH-1]);
            end
            ALU_DEC: begin
                res_s   = dec_s[WIDTH-1:0];
                carry_s = dec_s[WIDTH];
                ovf_s   = sub_ovf(a[WIDTH-1], 1'b0, dec_s[WIDTH-1]);
            end
            ALU_SHL: begin
                res_s   = shl_s[WIDTH-1:0];
                carry_s = shl_s[WIDTH];
            end
            ALU_SHR: begin
                res_s   = shr_s[WIDTH:1];
                carry_s = shr_s[0];
            end
            ALU_ASR: begin
                res_s   = asr_s[WIDTH:1];
                carry_s = asr_s[0];
            end
            ALU_MUL: err_s = !MUL_ON;
            default: err_s = 1'b1;
        endcase
    end

    // Output register and FSM: single-cycle ops load on accept, MUL loads on its final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            run_r       <= 1'b0;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            run_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && is_mul_s) begin
                        state_r     <= ST_MUL_BUSY;
                        out_valid_r <= 1'b0;
                    end else if (accept_s) begin
                        out_valid_r <= 1'b1;
                        result_r    <= res_s;
                        carry_r     <= carry_s;
                        zero_r      <= (res_s == {WIDTH{1'b0}});
                        ovf_r       <= ovf_s;
                        err_r       <= err_s;
                    end else if (xfer_s) begin
                        out_valid_r <= 1'b0;
                    end else begin
                        out_valid_r <= out_valid_r;
                    end
                end
                ST_MUL_BUSY: begin
                    if (mul_done_s) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b1;
                        result_r    <= mul_prod_s[WIDTH-1:0];
                        carry_r     <= mul_hi_s;
                        zero_r      <= (mul_prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
                        ovf_r       <= mul_hi_s;
                        err_r       <= 1'b0;
                    end else if (!mul_busy_s) begin
                        // Multiplier idle without finishing: recover rather than hang.
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_MUL_BUSY;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
